// File: rtl/diff_link_pkg.sv
// Shared definitions for the differential test link receive path.
//   rx_state_e    : word-alignment state (SEARCH, CONFIRM, LOCKED)
//   DEFAULT_COMMA : alignment pattern, MSB received first
//   ERR_CNT_W     : width of the saturating code-error counter
package diff_link_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  localparam logic [9:0] DEFAULT_COMMA = 10'b0011111010;
  localparam int         ERR_CNT_W     = 16;

endpackage

// File: rtl/diff_bit_sampler.sv
// Input flops for the differential pair.
// Ports:
//   clock    : sampling clock, posedge
//   reset    : synchronous, active-high
//   in_p_i   : positive leg
//   in_n_i   : negative leg
//   bit_o    : registered data bit (taken from the positive leg)
//   cerr_o   : registered code error, high when the two legs agree
module diff_bit_sampler (
  input  logic clock,
  input  logic reset,
  input  logic in_p_i,
  input  logic in_n_i,
  output logic bit_o,
  output logic cerr_o
);

  logic bit_q, bit_d;
  logic cerr_q, cerr_d;

  assign bit_d  = in_p_i;
  assign cerr_d = (in_p_i == in_n_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_q  <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      cerr_q <= cerr_d;
    end
  end

  assign bit_o  = bit_q;
  assign cerr_o = cerr_q;

endmodule

// File: rtl/differential_deserializer.sv
// Receive side of the differential test link. Samples the pair once per
// clock, deserializes into WIDTH-bit words, aligns word boundaries to COMMA,
// and emits words while locked. Code errors (both legs equal) are counted in
// every state.
// Ports:
//   clock, reset : clock (posedge) and synchronous active-high reset
//   in_p, in_n   : differential serial pair
//   clear_error  : clears error_flag and err_count
//   out_data     : last emitted word, MSB = earliest bit, held between pulses
//   out_valid    : one-cycle pulse per emitted word
//   out_comma    : emitted word equals COMMA with no code error
//   locked       : high while in LOCKED
//   error_flag   : sticky code-error indication
//   err_count    : saturating code-error bit count
module differential_deserializer
  import diff_link_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(DEFAULT_COMMA),
  parameter int               LOCK_COMMAS = 3,
  parameter int               ERR_LIMIT   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_p,
  input  logic                 in_n,
  input  logic                 clear_error,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_comma,
  output logic                 locked,
  output logic                 error_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]     LOCK_N   = 4'(LOCK_COMMAS);
  localparam logic [3:0]     ERR_N    = 4'(ERR_LIMIT);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // ---- sample stage ----
  logic bit_s, cerr_s;

  diff_bit_sampler u_sampler (
    .clock  (clock),
    .reset  (reset),
    .in_p_i (in_p),
    .in_n_i (in_n),
    .bit_o  (bit_s),
    .cerr_o (cerr_s)
  );

  // ---- shift / alignment stage ----
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] esr_q, esr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       hits_q, hits_d;
  logic [3:0]       errw_q, errw_d;
  rx_state_e        state_q, state_d;
  logic             word_rdy_q, word_rdy_d;
  logic             comma_hit, word_comma, wrap;

  // ---- output stage ----
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_comma_q, out_comma_d;
  logic                 locked_q, locked_d;
  logic                 error_flag_q, error_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign sr_d  = {sr_q[WIDTH-2:0], bit_s};
  assign esr_d = {esr_q[WIDTH-2:0], cerr_s};
  assign wrap  = (bit_cnt_q == LAST_BIT);

  // Alignment decisions look at the word as it will be after this shift.
  assign comma_hit  = (sr_d == COMMA) && (esr_d == '0);
  // Emission happens one cycle after the wrap, when sr_q holds the word.
  assign word_comma = (sr_q == COMMA) && (esr_q == '0);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = wrap ? '0 : bit_cnt_q + 1'b1;
    hits_d      = hits_q;
    errw_d      = errw_q;
    // Flag the word only when it completes inside LOCKED, so the comma that
    // finishes confirmation is never emitted.
    word_rdy_d  = (state_q == LOCKED) && wrap;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_comma_d = out_comma_q;

    case (state_q)
      SEARCH: begin
        if (comma_hit) begin
          state_d   = CONFIRM;
          bit_cnt_d = '0;
          hits_d    = 4'd1;
        end
      end
      CONFIRM: begin
        if (wrap) begin
          if (comma_hit) begin
            if (hits_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              hits_d  = 4'd0;
            end else begin
              hits_d  = hits_q + 4'd1;
            end
          end else begin
            state_d = SEARCH;
            hits_d  = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (word_rdy_q) begin
          out_data_d  = sr_q;
          out_valid_d = 1'b1;
          out_comma_d = word_comma;
          if (esr_q != '0) begin
            if (errw_q + 4'd1 == ERR_N) begin
              state_d = SEARCH;
              errw_d  = 4'd0;
            end else begin
              errw_d  = errw_q + 4'd1;
            end
          end else begin
            errw_d = 4'd0;
          end
        end
      end
      default: begin
        state_d = SEARCH;
        hits_d  = 4'd0;
        errw_d  = 4'd0;
      end
    endcase

    locked_d = (state_d == LOCKED);

    // A clear coincident with a fresh error leaves exactly that one error.
    if (clear_error) begin
      error_flag_d = cerr_s;
      err_count_d  = ERR_CNT_W'(cerr_s);
    end else if (cerr_s) begin
      error_flag_d = 1'b1;
      err_count_d  = sat_inc(err_count_q);
    end else begin
      error_flag_d = error_flag_q;
      err_count_d  = err_count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q         <= '0;
      esr_q        <= '0;
      bit_cnt_q    <= '0;
      hits_q       <= 4'd0;
      errw_q       <= 4'd0;
      state_q      <= SEARCH;
      word_rdy_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_comma_q  <= 1'b0;
      locked_q     <= 1'b0;
      error_flag_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      sr_q         <= sr_d;
      esr_q        <= esr_d;
      bit_cnt_q    <= bit_cnt_d;
      hits_q       <= hits_d;
      errw_q       <= errw_d;
      state_q      <= state_d;
      word_rdy_q   <= word_rdy_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_comma_q  <= out_comma_d;
      locked_q     <= locked_d;
      error_flag_q <= error_flag_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_comma  = out_comma_q;
  assign locked     = locked_q;
  assign error_flag = error_flag_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_differential_deserializer.sv
// Directed bench for differential_deserializer (WIDTH=10, LOCK_COMMAS=3,
// ERR_LIMIT=4). A negedge monitor records emitted words; the main sequence
// checks lock, emission, error accounting and reset behaviour.
module tb_differential_deserializer;

  localparam logic [9:0] COMMA_W = 10'b0011111010;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_p;
  logic        in_n;
  logic        clear_error;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_comma;
  logic        locked;
  logic        error_flag;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  int         vld_cnt = 0;
  logic [9:0] last_data = '0;
  logic       last_comma = 1'b0;
  int         base;

  differential_deserializer #(
    .WIDTH       (10),
    .COMMA       (COMMA_W),
    .LOCK_COMMAS (3),
    .ERR_LIMIT   (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_p        (in_p),
    .in_n        (in_n),
    .clear_error (clear_error),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_comma   (out_comma),
    .locked      (locked),
    .error_flag  (error_flag),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      vld_cnt    <= vld_cnt + 1;
      last_data  <= out_data;
      last_comma <= out_comma;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic bad);
    in_p = b;
    in_n = bad ? b : ~b;
    @(posedge clock);
    #1;
  endtask

  // bad_pos selects the bit index (9 = first sent) driven with equal legs; -1 = none.
  task automatic send_word(input logic [9:0] w, input int bad_pos);
    for (int i = 9; i >= 0; i--) send_bit(w[i], (i == bad_pos));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_p  = 1'b1;
    in_n  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_p        = 1'b1;
    in_n        = 1'b0;
    clear_error = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_data",  32'(out_data),   32'h0);
    check("rst_valid", 32'(out_valid),  32'h0);
    check("rst_comma", 32'(out_comma),  32'h0);
    check("rst_lock",  32'(locked),     32'h0);
    check("rst_eflag", 32'(error_flag), 32'h0);
    check("rst_ecnt",  32'(err_count),  32'h0);
    reset = 1'b0;

    // Lock at bit offset 7, then data words including a comma as data.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    check("t1_lock_after2", 32'(locked), 32'h0);
    send_word(COMMA_W, -1);
    check("t1_novalid_yet", 32'(vld_cnt), 32'd0);
    send_word(10'h155, -1);
    send_word(COMMA_W, -1);
    check("t1_locked",     32'(locked),     32'h1);
    check("t1_vld1",       32'(vld_cnt),    32'd1);
    check("t1_data1",      32'(last_data),  32'h155);
    check("t1_comma1",     32'(last_comma), 32'h0);
    send_word(10'h2AA, -1);
    check("t1_vld2",       32'(vld_cnt),    32'd2);
    check("t1_data2",      32'(last_data),  32'(COMMA_W));
    check("t1_comma2",     32'(last_comma), 32'h1);
    send_word(10'h0F0, -1);
    check("t1_vld3",       32'(vld_cnt),    32'd3);
    check("t1_data3",      32'(last_data),  32'h2AA);
    check("t1_comma3",     32'(last_comma), 32'h0);
    check("t1_hold",       32'(out_data),   32'h2AA);
    check("t1_eflag",      32'(error_flag), 32'h0);

    // Confirmation broken by a non-comma word.
    do_reset();
    base = vld_cnt;
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(10'h155, -1);
    send_word(10'h155, -1);
    check("t2_lock",  32'(locked),         32'h0);
    check("t2_vld",   32'(vld_cnt - base), 32'd0);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(10'h155, -1);
    send_word(10'h155, -1);
    check("t2_relock", 32'(locked),         32'h0);
    check("t2_vld2",   32'(vld_cnt - base), 32'd0);

    // Four consecutive errored words drop lock after the last is emitted.
    do_reset();
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    base = vld_cnt;
    send_word(10'h155, 3);
    send_word(10'h2AA, 0);
    send_word(10'h0F0, 9);
    send_word(10'h333, 5);
    check("t3_still_lock", 32'(locked),         32'h1);
    check("t3_vld3",       32'(vld_cnt - base), 32'd3);
    send_word(10'h155, -1);
    check("t3_unlock",     32'(locked),         32'h0);
    check("t3_vld4",       32'(vld_cnt - base), 32'd4);
    check("t3_lastdata",   32'(last_data),      32'h333);
    check("t3_ecnt",       32'(err_count),      32'd4);
    check("t3_eflag",      32'(error_flag),     32'h1);
    send_word(10'h155, -1);
    check("t3_novalid",    32'(vld_cnt - base), 32'd4);

    // A clean word restarts the consecutive-error run.
    do_reset();
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    base = vld_cnt;
    send_word(10'h155, 2);
    send_word(10'h155, -1);
    send_word(10'h2AA, 1);
    send_word(10'h2AA, 4);
    send_word(10'h0F0, 7);
    send_word(10'h155, -1);
    send_word(10'h155, -1);
    check("t4_lock", 32'(locked),         32'h1);
    check("t4_vld",  32'(vld_cnt - base), 32'd6);
    check("t4_ecnt", 32'(err_count),      32'd4);

    // Saturation, clear, and clear coincident with a new error.
    do_reset();
    repeat (70000) send_bit(1'b1, 1'b1);
    check("t5_sat",   32'(err_count),  32'hFFFF);
    check("t5_eflag", 32'(error_flag), 32'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t5_sat_hold", 32'(err_count), 32'hFFFF);
    clear_error = 1'b1;
    send_bit(1'b1, 1'b0);
    clear_error = 1'b0;
    check("t5_clr_cnt",  32'(err_count),  32'h0);
    check("t5_clr_flag", 32'(error_flag), 32'h0);
    send_bit(1'b0, 1'b1);
    clear_error = 1'b1;
    send_bit(1'b1, 1'b0);
    clear_error = 1'b0;
    check("t5_coinc_cnt",  32'(err_count),  32'h1);
    check("t5_coinc_flag", 32'(error_flag), 32'h1);
    send_bit(1'b1, 1'b0);
    check("t5_after_cnt",  32'(err_count),  32'h1);

    // Reset in the middle of a locked word.
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    base = vld_cnt;
    send_word(10'h155, -1);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("t6_pre_lock", 32'(locked),         32'h1);
    check("t6_pre_vld",  32'(vld_cnt - base), 32'd1);
    check("t6_pre_data", 32'(last_data),      32'h155);
    do_reset();
    check("t6_data",  32'(out_data),   32'h0);
    check("t6_valid", 32'(out_valid),  32'h0);
    check("t6_comma", 32'(out_comma),  32'h0);
    check("t6_lock",  32'(locked),     32'h0);
    check("t6_eflag", 32'(error_flag), 32'h0);
    check("t6_ecnt",  32'(err_count),  32'h0);
    base = vld_cnt;
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_word(10'h155, -1);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(10'h155, -1);
    check("t6_partial", 32'(vld_cnt - base), 32'd0);
    check("t6_nolock",  32'(locked),         32'h0);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    send_word(COMMA_W, -1);
    check("t6_vld_commas", 32'(vld_cnt - base), 32'd0);
    send_word(10'h2AA, -1);
    send_word(10'h0F0, -1);
    check("t6_relock", 32'(locked),         32'h1);
    check("t6_vld",    32'(vld_cnt - base), 32'd1);
    check("t6_word",   32'(last_data),      32'h2AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
